// File: rtl/arm_ctrl_pkg.sv
// Shared types, encodings and decode helpers for the multicycle ARM control unit.
// Included by the controller top and the condition/flag sub-module.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_control;
        logic [1:0] result_src;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;
    localparam ctrl_t CTRL_FETCH = '{pc_write: 1'b1, ir_write: 1'b1, adr_src: 1'b0,
                                     mem_write: 1'b0, reg_write: 1'b0, alu_src_a: 1'b1,
                                     alu_src_b: SRCB_FOUR, alu_control: ALU_ADD,
                                     result_src: RES_ALURESULT};
    localparam ctrl_t CTRL_DECODE = '{pc_write: 1'b0, ir_write: 1'b0, adr_src: 1'b0,
                                      mem_write: 1'b0, reg_write: 1'b0, alu_src_a: 1'b1,
                                      alu_src_b: SRCB_FOUR, alu_control: ALU_ADD,
                                      result_src: RES_ALURESULT};
    localparam ctrl_t CTRL_MEMADR = '{pc_write: 1'b0, ir_write: 1'b0, adr_src: 1'b0,
                                      mem_write: 1'b0, reg_write: 1'b0, alu_src_a: 1'b0,
                                      alu_src_b: SRCB_IMM, alu_control: ALU_ADD,
                                      result_src: RES_ALUOUT};
    localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b0, ir_write: 1'b0, adr_src: 1'b0,
                                      mem_write: 1'b0, reg_write: 1'b0, alu_src_a: 1'b0,
                                      alu_src_b: SRCB_IMM, alu_control: ALU_ADD,
                                      result_src: RES_ALURESULT};

    function automatic logic condcheck(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: return z;
            COND_NE: return ~z;
            COND_CS: return c;
            COND_CC: return ~c;
            COND_MI: return n;
            COND_PL: return ~n;
            COND_VS: return v;
            COND_VC: return ~v;
            COND_HI: return c & ~z;
            COND_LS: return ~(c & ~z);
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return ~z & (n == v);
            COND_LE: return z | (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Unrecognised commands fall back to an ADD whose result is discarded.
    function automatic logic [1:0] dp_alu(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: return ALU_ADD;
            CMD_SUB: return ALU_SUB;
            CMD_AND: return ALU_AND;
            CMD_ORR: return ALU_ORR;
            CMD_CMP: return ALU_SUB;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic dp_no_write(input logic [3:0] cmd);
        return !(cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_AND || cmd == CMD_ORR);
    endfunction

    function automatic logic dp_arith(input logic [3:0] cmd);
        return cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_CMP;
    endfunction

endpackage

// File: rtl/arm_cond_logic.sv
// NZCV flag register with per-pair write gating, condition evaluation against the
// registered flags, and the per-instruction latched execute decision.
module arm_cond_logic
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_write,
    input  logic       cond_latch,
    output logic       cond_ex,
    output logic       cond_ex_r
);

    logic [3:0] flags_reg;
    logic       cond_ex_reg;

    assign cond_ex   = condcheck(cond, flags_reg);
    assign cond_ex_r = cond_ex_reg;

    // flag_write[1] covers N,Z; flag_write[0] covers C,V.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_flag_pair
            always_ff @(posedge clk) begin
                if (!reset) begin
                    flags_reg[2*gi +: 2] <= FLAGS_RST[2*gi +: 2];
                end else if (flag_write[gi] && cond_ex_reg) begin
                    flags_reg[2*gi +: 2] <= alu_flags[2*gi +: 2];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            cond_ex_reg <= 1'b0;
        end else if (cond_latch) begin
            cond_ex_reg <= cond_ex;
        end
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: main FSM with registered datapath controls.
// Each transition loads the control word for the state being entered.
module arm_mc_controller
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] RegSrc,
    output logic [1:0] ImmSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ResultSrc
);

    state_t     state_reg;
    ctrl_t      ctrl_reg;
    logic       cond_ex;
    logic       cond_ex_r;
    logic [3:0] cmd;
    logic [1:0] dp_alu_control;
    logic       alu_write;
    logic       rd_is_pc;
    logic       exec_state;
    logic [1:0] flag_write;

    assign cmd            = Funct[4:1];
    assign dp_alu_control = dp_alu(cmd);
    assign alu_write      = cond_ex_r & ~dp_no_write(cmd);
    assign rd_is_pc       = (Rd == 4'hF);
    assign exec_state     = (state_reg == EXECR) || (state_reg == EXECI);
    assign flag_write     = {exec_state & Funct[0], exec_state & Funct[0] & dp_arith(cmd)};

    arm_cond_logic #(
        .FLAGS_RST (FLAGS_RST)
    ) u_cond (
        .clk        (clk),
        .reset      (reset),
        .cond       (Cond),
        .alu_flags  (ALUFlags),
        .flag_write (flag_write),
        .cond_latch (state_reg == DECODE),
        .cond_ex    (cond_ex),
        .cond_ex_r  (cond_ex_r)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= FETCH;
            ctrl_reg  <= CTRL_FETCH;
        end else begin
            ctrl_reg <= CTRL_IDLE;
            case (state_reg)
                FETCH: begin
                    state_reg <= DECODE;
                    ctrl_reg  <= CTRL_DECODE;
                end
                DECODE: begin
                    case (Op)
                        2'b01: begin
                            state_reg <= MEMADR;
                            ctrl_reg  <= CTRL_MEMADR;
                        end
                        2'b00: begin
                            state_reg            <= Funct[5] ? EXECI : EXECR;
                            ctrl_reg.alu_src_b   <= Funct[5] ? SRCB_IMM : SRCB_RD2;
                            ctrl_reg.alu_control <= dp_alu_control;
                        end
                        // Branch entry uses the live check: CondEx_r latches on this same edge.
                        2'b10: begin
                            state_reg         <= BRANCH;
                            ctrl_reg          <= CTRL_BRANCH;
                            ctrl_reg.pc_write <= cond_ex;
                        end
                        default: begin
                            state_reg <= FETCH;
                            ctrl_reg  <= CTRL_FETCH;
                        end
                    endcase
                end
                MEMADR: begin
                    state_reg          <= Funct[0] ? MEMRD : MEMWR;
                    ctrl_reg.adr_src   <= 1'b1;
                    ctrl_reg.mem_write <= ~Funct[0] & cond_ex_r;
                end
                MEMRD: begin
                    state_reg           <= MEMWB;
                    ctrl_reg.result_src <= RES_DATA;
                    ctrl_reg.reg_write  <= cond_ex_r;
                    ctrl_reg.pc_write   <= cond_ex_r & rd_is_pc;
                end
                EXECR, EXECI: begin
                    state_reg           <= ALUWB;
                    ctrl_reg.result_src <= RES_ALUOUT;
                    ctrl_reg.reg_write  <= alu_write;
                    ctrl_reg.pc_write   <= alu_write & rd_is_pc;
                end
                default: begin
                    state_reg <= FETCH;
                    ctrl_reg  <= CTRL_FETCH;
                end
            endcase
        end
    end

    // Enables are masked while reset is held so an aborted instruction writes nothing.
    assign PCWrite    = ctrl_reg.pc_write  & reset;
    assign IRWrite    = ctrl_reg.ir_write  & reset;
    assign MemWrite   = ctrl_reg.mem_write & reset;
    assign RegWrite   = ctrl_reg.reg_write & reset;
    assign AdrSrc     = ctrl_reg.adr_src;
    assign ALUSrcA    = ctrl_reg.alu_src_a;
    assign ALUSrcB    = ctrl_reg.alu_src_b;
    assign ALUControl = ctrl_reg.alu_control;
    assign ResultSrc  = ctrl_reg.result_src;
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == 2'b01, Op == 2'b10};

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed, table-driven bench: one record per clock cycle with the expected control word,
// followed by a hand-built reset-abort sequence during a store.
module tb_arm_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ALUSrcA;
    logic [1:0] RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc;

    always #5 clk = ~clk;

    arm_mc_controller #(.FLAGS_RST(4'b0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .RegSrc     (RegSrc),
        .ImmSrc     (ImmSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ResultSrc  (ResultSrc)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rd;
        logic [3:0]  fl;
        logic [15:0] exp;
        logic [63:0] name;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_step  = 0;

    // Control word layout: PCW IRW Adr MemW RegW RegSrc[1:0] ImmSrc[1:0] SrcA SrcB[1:0] ALUC[1:0] Res[1:0]
    function automatic logic [15:0] ctl(input logic pcw, input logic irw, input logic adr,
                                        input logic memw, input logic regw, input logic srca,
                                        input logic [1:0] srcb, input logic [1:0] aluc,
                                        input logic [1:0] res);
        return {pcw, irw, adr, memw, regw, 4'b0000, srca, srcb, aluc, res};
    endfunction

    function automatic vec_t mk(input logic rst, input logic [3:0] cond, input logic [1:0] op,
                                input logic [5:0] funct, input logic [3:0] rd,
                                input logic [3:0] fl, input logic [15:0] exp,
                                input logic [63:0] name);
        vec_t v;
        v.rst   = rst;
        v.cond  = cond;
        v.op    = op;
        v.funct = funct;
        v.rd    = rd;
        v.fl    = fl;
        v.exp   = exp | {5'b00000, op == 2'b01, op == 2'b10, op, 7'b0000000};
        v.name  = name;
        return v;
    endfunction

    localparam logic [15:0] E_FETCH  = 16'b1_1_0_0_0_0000_1_10_00_10;
    localparam logic [15:0] E_RSTF   = 16'b0_0_0_0_0_0000_1_10_00_10;
    localparam logic [15:0] E_DECODE = 16'b0_0_0_0_0_0000_1_10_00_10;
    localparam logic [15:0] E_MEMADR = 16'b0_0_0_0_0_0000_0_01_00_00;
    localparam logic [15:0] E_MEMRD  = 16'b0_0_1_0_0_0000_0_00_00_00;

    task automatic fd(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                      input logic [3:0] rd, input logic [3:0] fl);
        vecs.push_back(mk(1'b1, cond, op, funct, rd, fl, E_FETCH, "fetch"));
        vecs.push_back(mk(1'b1, cond, op, funct, rd, fl, E_DECODE, "decode"));
    endtask

    task automatic dp(input logic [3:0] cond, input logic [5:0] funct, input logic [3:0] rd,
                      input logic [3:0] fl, input logic [1:0] aluc, input logic regw,
                      input logic pcw);
        fd(cond, 2'b00, funct, rd, fl);
        vecs.push_back(mk(1'b1, cond, 2'b00, funct, rd, fl,
                          ctl(0, 0, 0, 0, 0, 0, funct[5] ? 2'b01 : 2'b00, aluc, 2'b00), "exec"));
        vecs.push_back(mk(1'b1, cond, 2'b00, funct, rd, fl,
                          ctl(pcw, 0, 0, 0, regw, 0, 2'b00, 2'b00, 2'b00), "aluwb"));
    endtask

    task automatic br(input logic [3:0] cond, input logic pcw);
        fd(cond, 2'b10, 6'b100000, 4'h0, 4'h0);
        vecs.push_back(mk(1'b1, cond, 2'b10, 6'b100000, 4'h0, 4'h0,
                          ctl(pcw, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b10), "branch"));
    endtask

    task automatic ld(input logic [3:0] cond, input logic [3:0] rd, input logic regw,
                      input logic pcw);
        fd(cond, 2'b01, 6'b011001, rd, 4'h0);
        vecs.push_back(mk(1'b1, cond, 2'b01, 6'b011001, rd, 4'h0, E_MEMADR, "memadr"));
        vecs.push_back(mk(1'b1, cond, 2'b01, 6'b011001, rd, 4'h0, E_MEMRD, "memrd"));
        vecs.push_back(mk(1'b1, cond, 2'b01, 6'b011001, rd, 4'h0,
                          ctl(pcw, 0, 0, 0, regw, 0, 2'b00, 2'b00, 2'b01), "memwb"));
    endtask

    task automatic st(input logic [3:0] cond, input logic memw);
        fd(cond, 2'b01, 6'b011000, 4'h7, 4'h0);
        vecs.push_back(mk(1'b1, cond, 2'b01, 6'b011000, 4'h7, 4'h0, E_MEMADR, "memadr"));
        vecs.push_back(mk(1'b1, cond, 2'b01, 6'b011000, 4'h7, 4'h0,
                          ctl(0, 0, 1, memw, 0, 0, 2'b00, 2'b00, 2'b00), "memwr"));
    endtask

    task automatic step(input vec_t v);
        logic [15:0] got;
        @(posedge clk);
        #1;
        reset    = v.rst;
        Cond     = v.cond;
        Op       = v.op;
        Funct    = v.funct;
        Rd       = v.rd;
        ALUFlags = v.fl;
        @(negedge clk);
        got = {PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ALUControl, ResultSrc};
        n_tests++;
        if (got !== v.exp) begin
            n_fail++;
            $display("FAIL step %0d %0s: got %b expected %b", n_step, v.name, got, v.exp);
        end else begin
            $display("ok   step %0d %0s: cond=%h op=%b funct=%b rd=%h -> %b",
                     n_step, v.name, v.cond, v.op, v.funct, v.rd, got);
        end
        n_step++;
    endtask

    initial begin
        reset    = 1'b0;
        Cond     = 4'h0;
        Op       = 2'b00;
        Funct    = 6'b0;
        Rd       = 4'h0;
        ALUFlags = 4'h0;

        vecs.push_back(mk(1'b0, 4'hE, 2'b00, 6'b0, 4'h0, 4'h0, E_RSTF, "rst"));
        vecs.push_back(mk(1'b0, 4'hE, 2'b00, 6'b0, 4'h0, 4'h0, E_RSTF, "rst"));
        dp(4'hE, 6'b101000, 4'h2, 4'h0, 2'b00, 1'b1, 1'b0);   // ADD R2,R0,#5
        dp(4'hE, 6'b010101, 4'h0, 4'b0100, 2'b01, 1'b0, 1'b0); // CMP -> Z
        br(4'b0000, 1'b1);                                     // BEQ taken
        br(4'b0001, 1'b0);                                     // BNE not taken
        dp(4'hE, 6'b010101, 4'h0, 4'b0000, 2'b01, 1'b0, 1'b0); // CMP -> clear
        br(4'b0000, 1'b0);
        dp(4'hE, 6'b010101, 4'h0, 4'b1000, 2'b01, 1'b0, 1'b0); // CMP -> N
        br(4'b1011, 1'b1);                                     // LT
        br(4'b1010, 1'b0);                                     // GE
        br(4'b1100, 1'b0);                                     // GT
        br(4'b0100, 1'b1);                                     // MI
        dp(4'hE, 6'b010101, 4'h0, 4'b0011, 2'b01, 1'b0, 1'b0); // CMP -> C,V
        dp(4'hE, 6'b000001, 4'h4, 4'b0100, 2'b10, 1'b1, 1'b0); // ANDS: N,Z only -> 0111
        br(4'b1000, 1'b0);                                     // HI
        br(4'b0010, 1'b1);                                     // CS kept
        br(4'b0110, 1'b1);                                     // VS kept
        dp(4'hF, 6'b010101, 4'h0, 4'b0000, 2'b01, 1'b0, 1'b0); // never-CMP: no update
        br(4'b0010, 1'b1);
        br(4'hF, 1'b0);
        br(4'hE, 1'b1);
        dp(4'hE, 6'b011000, 4'h5, 4'h0, 2'b11, 1'b1, 1'b0);    // ORR
        dp(4'hE, 6'b100100, 4'h6, 4'h0, 2'b01, 1'b1, 1'b0);    // SUB imm
        dp(4'hE, 6'b000010, 4'h6, 4'h0, 2'b00, 1'b0, 1'b0);    // EOR: unsupported
        ld(4'hE, 4'h3, 1'b1, 1'b0);                            // LDR
        ld(4'hE, 4'hF, 1'b1, 1'b1);                            // LDR PC
        ld(4'b0001, 4'h3, 1'b0, 1'b0);                         // LDRNE, Z=1
        st(4'hE, 1'b1);                                        // STR
        st(4'hF, 1'b0);
        dp(4'hE, 6'b001000, 4'hF, 4'h0, 2'b00, 1'b1, 1'b1);    // ADD PC
        dp(4'hF, 6'b001000, 4'hF, 4'h0, 2'b00, 1'b0, 1'b0);
        fd(4'hE, 2'b11, 6'b0, 4'h0, 4'h0);                     // undefined op: 2 cycles
        dp(4'hE, 6'b010101, 4'h0, 4'b0100, 2'b01, 1'b0, 1'b0); // CMP -> Z before abort

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        // Reset dropped in MEMWR: store suppressed, FSM and flags restart.
        vecs.delete();
        vecs.push_back(mk(1'b1, 4'hE, 2'b01, 6'b011000, 4'h7, 4'h0, E_FETCH, "s_fetch"));
        vecs.push_back(mk(1'b1, 4'hE, 2'b01, 6'b011000, 4'h7, 4'h0, E_DECODE, "s_decode"));
        vecs.push_back(mk(1'b1, 4'hE, 2'b01, 6'b011000, 4'h7, 4'h0, E_MEMADR, "s_memadr"));
        vecs.push_back(mk(1'b0, 4'hE, 2'b01, 6'b011000, 4'h7, 4'h0,
                          ctl(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00), "rst_abrt"));
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end
        vecs.delete();
        br(4'b0000, 1'b0);                                     // flags cleared: EQ false
        br(4'b0001, 1'b1);                                     // NE true
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
